// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice. The CPU and the
// instruction ROM use the same data/address width defaults.
//
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : bus width defaults (8 bits)
//   CNT_W                           : width of the secondary wait counter
//   arb_state_t                     : arbiter FSM state encoding
package mem_arbiter_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_wait_ctr.sv
// arb_wait_ctr
// Counts the cycles a pending secondary request has waited behind CPU
// traffic. It flags when the count reaches MAX_WAIT so the arbiter can
// force a one-cycle CPU stall.
//
// Optional feature (macro MEM_ARB_STATS_EN): also keeps a saturating
// 8-bit count of forced stalls, with a synchronous clear.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cnt_clr      : clear the wait counter (takes priority over cnt_inc)
//   cnt_inc      : increment the wait counter
//   at_max       : wait counter equals MAX_WAIT
//   force_entry  : (stats only) the arbiter is entering FORCE this cycle
//   stats_clr    : (stats only) clear stall_count, priority over increment
//   stall_count  : (stats only) saturating count of FORCE entries
module arb_wait_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt_clr,
    input  logic       cnt_inc,
    output logic       at_max
`ifdef MEM_ARB_STATS_EN
    ,
    input  logic       force_entry,
    input  logic       stats_clr,
    output logic [7:0] stall_count
`endif
);

    logic [CNT_W-1:0] cnt;

    // MAX_WAIT is at most 15, so the counter stops at the compare value
    // and never wraps.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == CNT_W'(MAX_WAIT));

`ifdef MEM_ARB_STATS_EN
    // Holds at 255 rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            stall_count <= '0;
        end else if (force_entry && (stall_count != 8'hFF)) begin
            stall_count <= stall_count + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single data-memory port between the CPU (zero-latency,
// combinational pass-through priority) and a secondary requester using a
// req/ack handshake. A pending secondary request that waits MAX_WAIT
// cycles behind CPU traffic gets a forced grant, with the CPU frozen for
// one cycle through cpu_stall.
//
// Optional feature (macro MEM_ARB_STATS_EN): adds stats_clr input and
// stall_count[7:0] output counting forced stalls.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cpu_write, cpu_read           : CPU access strobes
//   cpu_address, cpu_dout         : CPU address and write data
//   cpu_din                       : read data to the CPU (0 when not issued)
//   cpu_stall                     : registered CPU clock-enable low
//   dev_req, dev_we               : secondary request and direction
//   dev_addr, dev_wdata           : secondary address and write data
//   dev_ack                       : registered one-cycle completion pulse
//   dev_rdata                     : captured secondary read data
//   mem_write, mem_read           : memory strobes
//   mem_address, mem_wdata        : memory address and write data
//   mem_rdata                     : asynchronous memory read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_write,
    input  logic              cpu_read,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_stall,
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic              dev_ack,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [7:0]        stall_count
`endif
);

    arb_state_t state, state_next;
    logic       cpu_busy;
    logic       dev_issue;
    logic       cnt_clr, cnt_inc, at_max;
    logic       force_entry;

    assign cpu_busy = cpu_read | cpu_write;

    arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
        .clk         (clk),
        .rst         (rst),
        .cnt_clr     (cnt_clr),
        .cnt_inc     (cnt_inc),
        .at_max      (at_max)
`ifdef MEM_ARB_STATS_EN
        ,
        .force_entry (force_entry),
        .stats_clr   (stats_clr),
        .stall_count (stall_count)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dev_ack   <= 1'b0;
            cpu_stall <= 1'b0;
            dev_rdata <= '0;
        end else begin
            state     <= state_next;
            dev_ack   <= (state_next == ACK);
            cpu_stall <= force_entry;
            if (dev_issue && !dev_we) begin
                dev_rdata <= mem_rdata;
            end
        end
    end

    // The counter is zero in IDLE, so the increment on IDLE->WAIT loads 1.
    // In ACK dev_req is ignored; a held request restarts from IDLE.
    always_comb begin
        state_next  = state;
        dev_issue   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        force_entry = 1'b0;
        case (state)
            IDLE: begin
                if (dev_req && !cpu_busy) begin
                    dev_issue  = 1'b1;
                    state_next = ACK;
                end else if (dev_req) begin
                    cnt_inc    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!dev_req) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end else if (!cpu_busy) begin
                    dev_issue  = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ACK;
                end else if (at_max) begin
                    cnt_clr     = 1'b1;
                    force_entry = 1'b1;
                    state_next  = FORCE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FORCE: begin
                dev_issue  = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset gates both strobes so no access, including a pending forced
    // write, reaches memory during a reset cycle.
    always_comb begin
        mem_address = cpu_address;
        mem_wdata   = cpu_dout;
        mem_write   = cpu_write;
        mem_read    = cpu_read;
        cpu_din     = mem_rdata;
        if (dev_issue) begin
            mem_address = dev_addr;
            mem_wdata   = dev_wdata;
            mem_write   = dev_we;
            mem_read    = ~dev_we;
            cpu_din     = '0;
        end
        if (rst) begin
            mem_write = 1'b0;
            mem_read  = 1'b0;
            cpu_din   = '0;
        end
    end

endmodule
